// File: rtl/atm_keypad_frontend.sv
// Keypad/card-reader front end: turns raw key strobes and card level into the
// ATM controller handshake (card pulse, transaction type, PIN digits, amount).
module atm_keypad_frontend #(
    parameter int PIN_DIGITS        = 4,
    parameter int MAX_AMOUNT_DIGITS = 9,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tarjeta_insertada,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    input  logic        balance_actualizado,
    input  logic        fondos_insuficientes,
    output logic        tarjeta_recibida,
    output logic        tipo_trans,
    output logic        add_digit,
    output logic [3:0]  digito,
    output logic        monto_stb,
    output logic [31:0] monto,
    output logic        entry_error,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_PIN     = 3'd2,
        ST_AMOUNT  = 3'd3,
        ST_DONE    = 3'd4,
        ST_LOCKED  = 3'd5
    } state_t;

    localparam logic [3:0]  KEY_ENTER    = 4'hA;
    localparam logic [3:0]  KEY_CLEAR    = 4'hB;
    localparam logic [3:0]  KEY_DEPOSIT  = 4'hC;
    localparam logic [3:0]  KEY_WITHDRAW = 4'hD;
    localparam logic [3:0]  PIN_LAST     = 4'(PIN_DIGITS - 1);
    localparam logic [3:0]  AMT_MAX      = 4'(MAX_AMOUNT_DIGITS);
    localparam logic [31:0] TIMER_LAST   = 32'(TIMEOUT_CYCLES - 1);

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic [31:0] acc_push(input logic [31:0] acc, input logic [3:0] code);
        return (acc * 32'd10) + {28'd0, code};
    endfunction

    state_t      state_r, state_s;
    logic        card_d_r, pinc_d_r;
    logic [3:0]  pin_cnt_r, pin_cnt_s;
    logic [3:0]  amt_cnt_r, amt_cnt_s;
    logic [31:0] acc_r, acc_s;
    logic [31:0] timer_r, timer_s;
    logic        tr_s, tipo_s, add_s, mstb_s, err_s, to_s;
    logic [3:0]  digito_s;
    logic [31:0] monto_s;
    logic        card_rise_s, pinc_rise_s, digit_key_s, timed_s, expire_s;

    assign card_rise_s = tarjeta_insertada & ~card_d_r;
    assign pinc_rise_s = pin_incorrecto & ~pinc_d_r;
    assign digit_key_s = key_valid & is_digit(key_code);
    assign timed_s     = (state_r == ST_SELECT) || (state_r == ST_PIN) || (state_r == ST_AMOUNT);
    assign expire_s    = timed_s && !key_valid && (timer_r == TIMER_LAST);

    // Next-state, datapath and output decode; card removal, lock and timeout outrank keys.
    always_comb begin
        state_s   = state_r;
        pin_cnt_s = pin_cnt_r;
        amt_cnt_s = amt_cnt_r;
        acc_s     = acc_r;
        tr_s      = 1'b0;
        tipo_s    = tipo_trans;
        add_s     = 1'b0;
        digito_s  = digito;
        mstb_s    = 1'b0;
        monto_s   = monto;
        err_s     = 1'b0;
        to_s      = 1'b0;
        if (state_r == ST_IDLE) begin
            pin_cnt_s = 4'd0;
            amt_cnt_s = 4'd0;
            acc_s     = 32'd0;
            if (card_rise_s) begin
                tr_s    = 1'b1;
                state_s = ST_SELECT;
            end else begin
                state_s = ST_IDLE;
            end
        end else if (!tarjeta_insertada) begin
            state_s   = ST_IDLE;
            pin_cnt_s = 4'd0;
            amt_cnt_s = 4'd0;
            acc_s     = 32'd0;
        end else if (bloqueo && (state_r != ST_LOCKED)) begin
            state_s = ST_LOCKED;
        end else if (expire_s) begin
            to_s      = 1'b1;
            state_s   = ST_IDLE;
            pin_cnt_s = 4'd0;
            amt_cnt_s = 4'd0;
            acc_s     = 32'd0;
        end else begin
            case (state_r)
                ST_SELECT: begin
                    if (key_valid && (key_code == KEY_DEPOSIT)) begin
                        tipo_s  = 1'b0;
                        state_s = ST_PIN;
                    end else if (key_valid && (key_code == KEY_WITHDRAW)) begin
                        tipo_s  = 1'b1;
                        state_s = ST_PIN;
                    end else if (digit_key_s || (key_valid && (key_code == KEY_ENTER))) begin
                        err_s = 1'b1;
                    end else begin
                        state_s = ST_SELECT;
                    end
                end
                ST_PIN: begin
                    if (digit_key_s) begin
                        add_s    = 1'b1;
                        digito_s = key_code;
                        if (pin_cnt_r == PIN_LAST) begin
                            pin_cnt_s = 4'd0;
                            state_s   = ST_AMOUNT;
                        end else begin
                            pin_cnt_s = pin_cnt_r + 4'd1;
                        end
                    end else begin
                        state_s = ST_PIN;
                    end
                end
                ST_AMOUNT: begin
                    if (pinc_rise_s) begin
                        acc_s     = 32'd0;
                        amt_cnt_s = 4'd0;
                        state_s   = ST_PIN;
                    end else if (digit_key_s) begin
                        // Leading zeros neither count nor change the value.
                        if ((acc_r == 32'd0) && (key_code == 4'd0)) begin
                            acc_s = acc_r;
                        end else if (amt_cnt_r < AMT_MAX) begin
                            acc_s     = acc_push(acc_r, key_code);
                            amt_cnt_s = amt_cnt_r + 4'd1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else if (key_valid && (key_code == KEY_CLEAR)) begin
                        acc_s     = 32'd0;
                        amt_cnt_s = 4'd0;
                    end else if (key_valid && (key_code == KEY_ENTER)) begin
                        if (acc_r == 32'd0) begin
                            err_s = 1'b1;
                        end else begin
                            monto_s   = acc_r;
                            mstb_s    = 1'b1;
                            acc_s     = 32'd0;
                            amt_cnt_s = 4'd0;
                            state_s   = ST_DONE;
                        end
                    end else begin
                        state_s = ST_AMOUNT;
                    end
                end
                ST_DONE: begin
                    if (balance_actualizado || fondos_insuficientes) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                ST_LOCKED: state_s = ST_LOCKED;
                default:   state_s = ST_IDLE;
            endcase
        end
        // Inactivity timer restarts on every key and on every state change.
        if ((state_s != state_r) || key_valid || !timed_s) begin
            timer_s = 32'd0;
        end else begin
            timer_s = timer_r + 32'd1;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            card_d_r         <= 1'b0;
            pinc_d_r         <= 1'b0;
            pin_cnt_r        <= 4'd0;
            amt_cnt_r        <= 4'd0;
            acc_r            <= 32'd0;
            timer_r          <= 32'd0;
            tarjeta_recibida <= 1'b0;
            tipo_trans       <= 1'b0;
            add_digit        <= 1'b0;
            digito           <= 4'd0;
            monto_stb        <= 1'b0;
            monto            <= 32'd0;
            entry_error      <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            state_r          <= state_s;
            card_d_r         <= tarjeta_insertada;
            pinc_d_r         <= pin_incorrecto;
            pin_cnt_r        <= pin_cnt_s;
            amt_cnt_r        <= amt_cnt_s;
            acc_r            <= acc_s;
            timer_r          <= timer_s;
            tarjeta_recibida <= tr_s;
            tipo_trans       <= tipo_s;
            add_digit        <= add_s;
            digito           <= digito_s;
            monto_stb        <= mstb_s;
            monto            <= monto_s;
            entry_error      <= err_s;
            timeout          <= to_s;
        end
    end

endmodule

// File: doc/atm_keypad_frontend.md
Name: atm_keypad_frontend

Overview:
- Keypad/card-reader front end that drives the ATM controller's input interface.
- Converts raw key strobes into the controller's handshake:
  - card-received pulse
  - transaction type
  - one-cycle PIN digit pulses (add_digit/digito)
  - a binary amount with a one-cycle strobe (monto/monto_stb)
- Watches controller status outputs to sequence the session and return to idle.

Parameters:
- PIN_DIGITS, 4, digits forwarded per PIN attempt (1..8).
- MAX_AMOUNT_DIGITS, 9, maximum significant decimal amount digits (1..9, guarantees no 32-bit overflow).
- TIMEOUT_CYCLES, 1000000, inactivity cycles before abandoning a session (≥2).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- tarjeta_insertada  in  1  card-present level from card reader
- key_valid  in  1  one-cycle key strobe from keypad scanner
- key_code  in  4  0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC DEPOSIT, 0xD WITHDRAW, others ignored
- pin_incorrecto  in  1  controller status, level
- bloqueo  in  1  controller lock status, level
- balance_actualizado  in  1  controller completion status, level
- fondos_insuficientes  in  1  controller completion status, level
- tarjeta_recibida  out  1  one-cycle pulse to controller
- tipo_trans  out  1  1 = withdrawal, 0 = deposit; registered, held
- add_digit  out  1  one-cycle PIN digit strobe
- digito  out  4  PIN digit, valid with add_digit, held afterwards
- monto_stb  out  1  one-cycle amount strobe
- monto  out  32  binary amount, valid with monto_stb, held until next strobe
- entry_error  out  1  one-cycle pulse on rejected key
- timeout  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset: rst low asynchronously forces state IDLE, all outputs 0, monto 0, digit/amount counters, accumulator and timer cleared, edge-detect registers 0.
- All outputs registered; key_valid in cycle N produces its response in cycle N+1.
- States and transitions:
  - IDLE:
    - rising edge of tarjeta_insertada (registered edge detect) -> tarjeta_recibida pulse, go SELECT.
    - Keys are ignored.
  - SELECT:
    - DEPOSIT -> tipo_trans=0, go PIN_ENTRY.
    - WITHDRAW -> tipo_trans=1, go PIN_ENTRY.
    - Digit/ENTER -> entry_error pulse.
    - CLEAR and other codes are ignored.
  - PIN_ENTRY:
    - Digit -> add_digit=1, digito=key_code for exactly one cycle; pin_cnt++.
    - When pin_cnt reaches PIN_DIGITS -> go AMOUNT_ENTRY, pin_cnt=0.
    - Non-digit keys are ignored; digits are never buffered or dropped.
  - AMOUNT_ENTRY:
    - Digit with acc==0 and digit==0 -> ignored (leading zero, count unchanged).
    - Other digit with amt_cnt<MAX_AMOUNT_DIGITS -> acc=acc*10+digit (32-bit), amt_cnt++.
    - Digit with amt_cnt==MAX_AMOUNT_DIGITS -> entry_error, acc unchanged.
    - CLEAR -> acc=0, amt_cnt=0.
    - ENTER with acc==0 -> entry_error, stay.
    - ENTER with acc>0 -> monto=acc, monto_stb pulse, go DONE_WAIT.
    - Rising edge of pin_incorrecto -> acc=0, amt_cnt=0, go PIN_ENTRY (retry).
  - DONE_WAIT:
    - balance_actualizado or fondos_insuficientes high -> IDLE.
    - Keys are ignored.
  - LOCKED:
    - Keys are ignored.
    - Leaves only on card removal.
- Global priorities, checked before per-state rules:
  - tarjeta_insertada low in any non-IDLE state -> IDLE, acc/counters cleared, no strobe issued that cycle, even if key_valid is simultaneous.
  - Else bloqueo high in any non-IDLE, non-LOCKED state -> LOCKED.
- Timeout:
  - Timer counts cycles in SELECT, PIN_ENTRY and AMOUNT_ENTRY.
  - Reloads on any key_valid and on state entry.
  - Reaching TIMEOUT_CYCLES -> timeout pulse, go IDLE.
  - After a timeout, the card must be removed and reinserted to restart.
- Strobes:
  - add_digit, monto_stb, tarjeta_recibida, entry_error and timeout are never high for more than one consecutive cycle.
  - add_digit and monto_stb are mutually exclusive.
- Reset mid-session: immediate IDLE, any pending strobe suppressed.

Test Plan:
- Insert card, WITHDRAW, digits 4,7,5,6 -> tarjeta_recibida one pulse; tipo_trans=1; four add_digit pulses with digito 4,7,5,6, each one cycle after its key_valid; state AMOUNT_ENTRY.
- Amount keys 0,0,1,2,5,ENTER -> monto=125, single monto_stb one cycle after ENTER; balance_actualizado=1 -> IDLE.
- Ten digits 9 then ENTER -> tenth digit gives entry_error; monto=999999999 strobed; ENTER on empty entry -> entry_error, no monto_stb.
- Card removed in the same cycle as a digit key during PIN_ENTRY -> no add_digit, state IDLE, counters 0.
- pin_incorrecto rises in AMOUNT_ENTRY after 2 amount digits -> acc cleared, PIN_ENTRY, next 4 digits forwarded; bloqueo high -> LOCKED, keys ignored until card removed.
- TIMEOUT_CYCLES=16, no keys after DEPOSIT -> timeout pulse at cycle 16, IDLE; async rst pulse mid-AMOUNT_ENTRY -> all outputs 0 immediately.
